// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction fetch stage and IF/ID pipeline register.
//
// Holds the fetch PC, drives the instruction-memory address from it, and
// latches the returned word with its PC into the IF/ID register one cycle
// later. The hazard unit can hold the stage (stall) and the resolving branch
// unit can squash it and redirect fetch (flush). Flush beats stall.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   stall        hold PC and IF/ID contents
//   flush        squash IF/ID to a bubble, redirect PC to redirect_pc
//   redirect_pc  redirect target, low two bits ignored
//   imem_addr    instruction-memory read address (= pc)
//   imem_rdata   instruction word at imem_addr, same cycle
//   id_inst      IF/ID instruction word (NOP_INST for a bubble)
//   id_pc        PC of id_inst (0 for a bubble)
//   id_pc_plus4  id_pc + 4, used as the link address
//   id_valid     1 for a real fetched instruction, 0 for a bubble
//   fetch_count  number of instructions latched into IF/ID (wraps)
module fetch_ifid #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // Redirect targets are forced word-aligned, so the low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      // The target becomes the very next fetch address; the only lost slot
      // is the squashed one now sitting in IF/ID.
      pc_d          = {redirect_pc[31:2], 2'b00};
      id_inst_d     = NOP_INST;
      id_pc_d       = 32'h0000_0000;
      id_pc_plus4_d = 32'h0000_0000;
      id_valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_plus4;
      id_inst_d     = imem_rdata;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= PC_RESET;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= 32'h0000_0000;
      id_pc_plus4_q <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // All IF/ID outputs come straight from flops; only imem_addr follows pc.
  assign imem_addr   = pc_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ifid.sv
module tb_fetch_ifid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_rdata, id_inst, id_pc, id_pc_plus4, fetch_count;
  logic        id_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_id_inst, w_id_pc, w_id_pc_plus4, w_fetch_count;
  logic        w_id_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: word at addr is addr | 32'hA000_0000.
  assign imem_rdata   = imem_addr   | 32'hA000_0000;
  assign w_imem_rdata = w_imem_addr | 32'hA000_0000;

  fetch_ifid u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  fetch_ifid #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (w_imem_addr),
    .imem_rdata  (w_imem_rdata),
    .id_inst     (w_id_inst),
    .id_pc       (w_id_pc),
    .id_pc_plus4 (w_id_pc_plus4),
    .id_valid    (w_id_valid),
    .fetch_count (w_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_addr"},   imem_addr,   32'h0);
    check({tag, " id_inst"},     id_inst,     32'h0000_0013);
    check({tag, " id_pc"},       id_pc,       32'h0);
    check({tag, " id_pc_plus4"}, id_pc_plus4, 32'h0);
    check({tag, " id_valid"},    {31'b0, id_valid}, 32'h0);
    check({tag, " fetch_count"}, fetch_count, 32'h0);
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    check({tag, " id_pc"},       id_pc,       pc);
    check({tag, " id_inst"},     id_inst,     pc | 32'hA000_0000);
    check({tag, " id_pc_plus4"}, id_pc_plus4, pc + 32'd4);
    check({tag, " id_valid"},    {31'b0, id_valid}, 32'h1);
    check({tag, " fetch_count"}, fetch_count, cnt);
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
    check({tag, " id_inst"},     id_inst,     32'h0000_0013);
    check({tag, " id_pc"},       id_pc,       32'h0);
    check({tag, " id_pc_plus4"}, id_pc_plus4, 32'h0);
    check({tag, " id_valid"},    {31'b0, id_valid}, 32'h0);
    check({tag, " imem_addr"},   imem_addr,   addr);
    check({tag, " fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    #6;
    check_reset_vals("rst");
    check("rst wrap imem_addr", w_imem_addr, 32'hFFFF_FFFC);
    #5 rst_n = 1'b1;

    // Sequential fetch from reset.
    step();
    check_id("seq0", 32'h0, 32'd1);
    check("seq0 imem_addr", imem_addr, 32'h4);
    check("wrap id_pc", w_id_pc, 32'hFFFF_FFFC);
    check("wrap id_pc_plus4", w_id_pc_plus4, 32'h0);
    check("wrap imem_addr", w_imem_addr, 32'h0);
    check("wrap id_inst", w_id_inst, 32'hFFFF_FFFC);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_id("seq", 32'(4 * i), 32'(i + 1));
    end
    check("seq imem_addr", imem_addr, 32'h10);

    // Stall three cycles at pc = 0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall imem_addr", imem_addr, 32'h10);
      check_id("stall hold", 32'hC, 32'd4);
    end
    stall = 1'b0;
    step();
    check_id("unstall", 32'h10, 32'd5);
    check("unstall imem_addr", imem_addr, 32'h14);

    // Flush with misaligned target.
    flush = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    check_bubble("flush", 32'h200, 32'd5);
    flush = 1'b0;
    step();
    check_id("after flush", 32'h200, 32'd6);
    check("after flush imem_addr", imem_addr, 32'h204);

    // Flush and stall together: flush wins.
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h400;
    step();
    check_bubble("flush+stall", 32'h400, 32'd6);
    flush = 1'b0;
    step();
    check_bubble("stall after flush", 32'h400, 32'd6);
    stall = 1'b0;
    step();
    check_id("redirect fetched", 32'h400, 32'd7);

    // Get to pc = 0x40 with a real instruction in IF/ID, then stall.
    flush = 1'b1; redirect_pc = 32'h3C;
    step();
    check_bubble("flush 3c", 32'h3C, 32'd7);
    flush = 1'b0;
    step();
    check_id("fetch 3c", 32'h3C, 32'd8);
    check("pc 40", imem_addr, 32'h40);
    stall = 1'b1;
    step();
    check("stalled pc 40", imem_addr, 32'h40);

    // Asynchronous reset between edges while stalled.
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("async rst");
    flush = 1'b1; redirect_pc = 32'h800;
    step();
    check_reset_vals("rst over flush");
    flush = 1'b0; stall = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check_id("post rst", 32'h0, 32'd1);
    check("post rst imem_addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
